// File: rtl/regfile_wport_arbiter.sv
// regfile_wport_arbiter: shares the register file write port between WB and MC and tracks pending MC results
//
// Ports:
//   i_clk, i_reset_n                     clock, asynchronous active-low reset
//   i_wb_req/i_wb_addr/i_wb_data         write-back stage write request (held until o_wb_gnt)
//   o_wb_gnt                             combinational grant to WB
//   i_mc_req/i_mc_addr/i_mc_data         multi-cycle unit write request (held until o_mc_gnt)
//   o_mc_gnt                             combinational grant to MC
//   i_issue_valid/i_issue_long/i_issue_dest  decode issue info; long ops mark dest pending
//   i_rd_addr1, i_rd_addr2               decode source registers
//   o_rd_stall                           a source register awaits an MC result
//   o_issue_stall                        issue destination awaits an MC result (WAW)
//   o_rf_write/o_rf_addr3/o_rf_data3     registered write port to the register file
//   o_byp_hit1/o_byp_hit2/o_byp_data     in-flight write forwarding (only with RF_BYPASS_EN)
//
// Optional feature macro: RF_BYPASS_EN
module regfile_wport_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_req,
    input  logic [1:0]  i_wb_addr,
    input  logic [15:0] i_wb_data,
    output logic        o_wb_gnt,
    input  logic        i_mc_req,
    input  logic [1:0]  i_mc_addr,
    input  logic [15:0] i_mc_data,
    output logic        o_mc_gnt,
    input  logic        i_issue_valid,
    input  logic        i_issue_long,
    input  logic [1:0]  i_issue_dest,
    input  logic [1:0]  i_rd_addr1,
    input  logic [1:0]  i_rd_addr2,
    output logic        o_rd_stall,
    output logic        o_issue_stall,
`ifdef RF_BYPASS_EN
    output logic        o_byp_hit1,
    output logic        o_byp_hit2,
    output logic [15:0] o_byp_data,
`endif
    output logic        o_rf_write,
    output logic [1:0]  o_rf_addr3,
    output logic [15:0] o_rf_data3
);

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_sb;
    logic             w_starve;
    logic [3:0]       w_sb_set;
    logic [3:0]       w_sb_clr;

    always_comb begin
        w_starve      = r_cnt >= CNT_W'(STARVE_LIMIT);
        o_mc_gnt      = i_mc_req & (~i_wb_req | w_starve);
        o_wb_gnt      = i_wb_req & ~o_mc_gnt;
        o_rd_stall    = r_sb[i_rd_addr1] | r_sb[i_rd_addr2];
        o_issue_stall = i_issue_valid & r_sb[i_issue_dest];
        w_sb_set      = (i_issue_valid & i_issue_long & ~o_issue_stall) ? (4'b0001 << i_issue_dest) : 4'b0000;
        w_sb_clr      = o_mc_gnt ? (4'b0001 << i_mc_addr) : 4'b0000;
    end

`ifdef RF_BYPASS_EN
    always_comb begin
        o_byp_hit1 = o_rf_write & (o_rf_addr3 == i_rd_addr1);
        o_byp_hit2 = o_rf_write & (o_rf_addr3 == i_rd_addr2);
        o_byp_data = o_rf_data3;
    end
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rf_write <= 1'b0;
            o_rf_addr3 <= 2'd0;
            o_rf_data3 <= 16'd0;
            r_sb       <= 4'b0000;
            r_cnt      <= '0;
        end else begin
            o_rf_write <= o_wb_gnt | o_mc_gnt;
            if (o_mc_gnt) begin
                o_rf_addr3 <= i_mc_addr;
                o_rf_data3 <= i_mc_data;
            end else if (o_wb_gnt) begin
                o_rf_addr3 <= i_wb_addr;
                o_rf_data3 <= i_wb_data;
            end
            // set applied after clear: a new long issue outranks the older op's completion
            r_sb  <= (r_sb & ~w_sb_clr) | w_sb_set;
            r_cnt <= (i_mc_req & ~o_mc_gnt) ? ((&r_cnt) ? r_cnt : r_cnt + CNT_W'(1)) : '0;
        end
    end

`ifndef SYNTHESIS
    logic        r_wb_hold;
    logic        r_mc_hold;
    logic [1:0]  r_wb_addr_q;
    logic [1:0]  r_mc_addr_q;
    logic [15:0] r_wb_data_q;
    logic [15:0] r_mc_data_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wb_hold <= 1'b0;
            r_mc_hold <= 1'b0;
        end else begin
            r_wb_hold <= i_wb_req & ~o_wb_gnt;
            r_mc_hold <= i_mc_req & ~o_mc_gnt;
        end
    end

    always_ff @(posedge i_clk) begin
        r_wb_addr_q <= i_wb_addr;
        r_wb_data_q <= i_wb_data;
        r_mc_addr_q <= i_mc_addr;
        r_mc_data_q <= i_mc_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset_n) begin
            assert (!o_mc_gnt || r_sb[i_mc_addr])
                else $error("mc_gnt for register %0d with no pending scoreboard entry", i_mc_addr);
            assert (!(r_wb_hold && i_wb_req) || (i_wb_addr == r_wb_addr_q && i_wb_data == r_wb_data_q))
                else $error("WB changed addr/data while waiting for grant");
            assert (!(r_mc_hold && i_mc_req) || (i_mc_addr == r_mc_addr_q && i_mc_data == r_mc_data_q))
                else $error("MC changed addr/data while waiting for grant");
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// tb_regfile_wport_arbiter: directed self-checking bench for regfile_wport_arbiter
module tb_regfile_wport_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wb_req, mc_req, wb_gnt, mc_gnt;
    logic [1:0]  wb_addr, mc_addr, issue_dest, rd_addr1, rd_addr2, rf_addr3;
    logic [15:0] wb_data, mc_data, rf_data3;
    logic        issue_valid, issue_long, rd_stall, issue_stall, rf_write;
`ifdef RF_BYPASS_EN
    logic        byp_hit1, byp_hit2;
    logic [15:0] byp_data;
`endif
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    regfile_wport_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .i_clk(clk), .i_reset_n(reset_n),
        .i_wb_req(wb_req), .i_wb_addr(wb_addr), .i_wb_data(wb_data), .o_wb_gnt(wb_gnt),
        .i_mc_req(mc_req), .i_mc_addr(mc_addr), .i_mc_data(mc_data), .o_mc_gnt(mc_gnt),
        .i_issue_valid(issue_valid), .i_issue_long(issue_long), .i_issue_dest(issue_dest),
        .i_rd_addr1(rd_addr1), .i_rd_addr2(rd_addr2),
        .o_rd_stall(rd_stall), .o_issue_stall(issue_stall),
`ifdef RF_BYPASS_EN
        .o_byp_hit1(byp_hit1), .o_byp_hit2(byp_hit2), .o_byp_data(byp_data),
`endif
        .o_rf_write(rf_write), .o_rf_addr3(rf_addr3), .o_rf_data3(rf_data3)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with WB already requesting: grants are combinational even in reset
        reset_n = 1'b0; wb_req = 1'b1; wb_addr = 2'd0; wb_data = 16'h0;
        mc_req = 1'b0; mc_addr = 2'd0; mc_data = 16'h0;
        issue_valid = 1'b0; issue_long = 1'b0; issue_dest = 2'd0;
        rd_addr1 = 2'd0; rd_addr2 = 2'd0;
        #1;
        check("rst_rf_write", 16'(rf_write), 16'd0);
        check("rst_rf_addr3", 16'(rf_addr3), 16'd0);
        check("rst_rf_data3", rf_data3, 16'h0);
        check("rst_wb_gnt_comb", 16'(wb_gnt), 16'd1);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1; wb_req = 1'b0;
        @(negedge clk);
        check("idle_rf_write", 16'(rf_write), 16'd0);
        check("idle_rf_data3", rf_data3, 16'h0);
        check("idle_wb_gnt", 16'(wb_gnt), 16'd0);
        check("idle_mc_gnt", 16'(mc_gnt), 16'd0);
        check("idle_rd_stall", 16'(rd_stall), 16'd0);

        // WB alone
        wb_req = 1'b1; wb_addr = 2'd2; wb_data = 16'hBEEF;
        #1;
        check("wb_gnt", 16'(wb_gnt), 16'd1);
        check("wb_alone_mc_gnt", 16'(mc_gnt), 16'd0);
        @(negedge clk);
        wb_req = 1'b0;
        check("wb_rf_write", 16'(rf_write), 16'd1);
        check("wb_rf_addr3", 16'(rf_addr3), 16'd2);
        check("wb_rf_data3", rf_data3, 16'hBEEF);
        @(negedge clk);
        check("wb_rf_write_drop", 16'(rf_write), 16'd0);
        check("wb_rf_data3_hold", rf_data3, 16'hBEEF);
        check("wb_rf_addr3_hold", 16'(rf_addr3), 16'd2);

        // long issue to r1 makes it pending
        issue_valid = 1'b1; issue_long = 1'b1; issue_dest = 2'd1; rd_addr1 = 2'd1;
        #1;
        check("iss1_issue_stall", 16'(issue_stall), 16'd0);
        check("iss1_rd_stall_same_cycle", 16'(rd_stall), 16'd0);
        @(negedge clk);
        issue_valid = 1'b0; issue_long = 1'b0;
        #1;
        check("iss1_rd_stall", 16'(rd_stall), 16'd1);

        // starvation: WB every cycle, MC to r1 waits STARVE_LIMIT cycles
        @(negedge clk);
        wb_req = 1'b1; wb_addr = 2'd0; wb_data = 16'h1111;
        mc_req = 1'b1; mc_addr = 2'd1; mc_data = 16'h1234;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("starve_wb_gnt_c%0d", i), 16'(wb_gnt), 16'd1);
            check($sformatf("starve_mc_gnt_c%0d", i), 16'(mc_gnt), 16'd0);
            @(negedge clk);
        end
        #1;
        check("starve_mc_gnt_c4", 16'(mc_gnt), 16'd1);
        check("starve_wb_gnt_c4", 16'(wb_gnt), 16'd0);
        check("starve_rd_stall_c4", 16'(rd_stall), 16'd1);
        check("starve_rf_data3_c4", rf_data3, 16'h1111);
        @(negedge clk);
        check("starve_rf_write_c5", 16'(rf_write), 16'd1);
        check("starve_rf_addr3_c5", 16'(rf_addr3), 16'd1);
        check("starve_rf_data3_c5", rf_data3, 16'h1234);
        #1;
        check("starve_rd_release_c5", 16'(rd_stall), 16'd0);
        check("cnt_cleared_wb_gnt", 16'(wb_gnt), 16'd1);
        check("cnt_cleared_mc_gnt", 16'(mc_gnt), 16'd0);
        @(negedge clk);
        wb_req = 1'b0; mc_req = 1'b0;

        // scoreboard hazard on r3
        issue_valid = 1'b1; issue_long = 1'b1; issue_dest = 2'd3; rd_addr2 = 2'd3;
        #1;
        check("haz_first_issue_stall", 16'(issue_stall), 16'd0);
        @(negedge clk);
        #1;
        check("haz_second_issue_stall", 16'(issue_stall), 16'd1);
        check("haz_rd_stall", 16'(rd_stall), 16'd1);
        @(negedge clk);
        issue_valid = 1'b0; issue_long = 1'b0;
        mc_req = 1'b1; mc_addr = 2'd3; mc_data = 16'h3333;
        #1;
        check("haz_mc_gnt", 16'(mc_gnt), 16'd1);
        check("haz_rd_stall_on_gnt", 16'(rd_stall), 16'd1);
        @(negedge clk);
        mc_req = 1'b0;
        #1;
        check("haz_rd_release", 16'(rd_stall), 16'd0);
        check("haz_rf_addr3", 16'(rf_addr3), 16'd3);
        check("haz_rf_data3", rf_data3, 16'h3333);

        // issue to r0 colliding with its own completion: the stall holds that cycle, entry clears
        @(negedge clk);
        issue_valid = 1'b1; issue_long = 1'b1; issue_dest = 2'd0; rd_addr1 = 2'd0; rd_addr2 = 2'd0;
        @(negedge clk);
        mc_req = 1'b1; mc_addr = 2'd0; mc_data = 16'h0A0A;
        #1;
        check("col_mc_gnt", 16'(mc_gnt), 16'd1);
        check("col_issue_stall", 16'(issue_stall), 16'd1);
        check("col_rd_stall", 16'(rd_stall), 16'd1);
        @(negedge clk);
        mc_req = 1'b0; issue_valid = 1'b0; issue_long = 1'b0;
        #1;
        check("col_rd_release", 16'(rd_stall), 16'd0);
        check("col_rf_data3", rf_data3, 16'h0A0A);

        // in-flight write, then asynchronous reset mid-operation
        @(negedge clk);
        issue_valid = 1'b1; issue_long = 1'b1; issue_dest = 2'd2;
        wb_req = 1'b1; wb_addr = 2'd1; wb_data = 16'h00FF;
        @(negedge clk);
        issue_valid = 1'b0; issue_long = 1'b0; wb_req = 1'b0;
        rd_addr1 = 2'd2;
        #1;
        check("byp_rf_write", 16'(rf_write), 16'd1);
        check("byp_rf_addr3", 16'(rf_addr3), 16'd1);
        check("pre_rst_rd_stall", 16'(rd_stall), 16'd1);
        rd_addr1 = 2'd1; rd_addr2 = 2'd0;
        #1;
`ifdef RF_BYPASS_EN
        check("byp_hit1", 16'(byp_hit1), 16'd1);
        check("byp_hit2", 16'(byp_hit2), 16'd0);
        check("byp_data", byp_data, 16'h00FF);
`endif
        reset_n = 1'b0;
        #1;
        check("midrst_rf_write", 16'(rf_write), 16'd0);
        check("midrst_rf_data3", rf_data3, 16'h0);
`ifdef RF_BYPASS_EN
        check("midrst_byp_hit1", 16'(byp_hit1), 16'd0);
`endif
        rd_addr1 = 2'd2;
        #1;
        check("midrst_sb_cleared", 16'(rd_stall), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_rf_write", 16'(rf_write), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
